memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Two-port arbiter placed between the instruction cache and the data-cache side of the memory controller, sharing the single main-memory port. Each requester holds a request until it gets a one-cycle done pulse. Arbitration is round-robin; only one transaction is in flight at a time. Address, write data and data type are latched at grant, so requesters may change their buses once granted.

## Interface
- ADDR_WIDTH, 17, byte address width
- LEN, 32, data word width
- clk  input  1  system clock, all state on posedge
- rst  input  1  asynchronous, active-high reset
- i_req  input  1  instruction fetch request (load only), level, held until i_done
- i_addr  input  ADDR_WIDTH  fetch address
- i_rdata  output  LEN  fetched word, valid with i_done
- i_done  output  1  one-cycle completion pulse
- d_req  input  1  data request, level, held until d_done
- d_we  input  1  1 = store, 0 = load
- d_addr  input  ADDR_WIDTH  data address
- d_wdata  input  LEN  store data
- d_data_type  input  3  ONE_BYTE/TWO_BYTE/FOUR_BYTE code
- d_rdata  output  LEN  load result, valid with d_done
- d_done  output  1  one-cycle completion pulse
- mem_req  output  1  request to main memory, held until mem_ready
- mem_we  output  1  store flag
- mem_addr  output  ADDR_WIDTH  latched address
- mem_wdata  output  LEN  latched store data
- mem_data_type  output  3  latched type; FOUR_BYTE for fetches
- mem_rdata  input  LEN  memory read data, valid with mem_ready
- mem_ready  input  1  one-cycle completion from memory
- grant  output  2  current owner: 00 none, 01 I, 10 D

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE: if exactly one request is present, grant it. If both are present, grant the port that was not granted last (last_grant register, reset value I, so D wins the first tie). Latch addr/wdata/we/type into the mem_* registers, set grant, and go to ISSUE.
- ISSUE: mem_req=1 and the mem_* outputs are stable. On mem_ready: latch mem_rdata into the owner's rdata register, clear mem_req, pulse the owner's done, go to DONE.
- DONE: one-cycle turnaround. Requests are ignored this cycle, so a requester that drops req on seeing done is not re-granted. Update last_grant, set grant=00, go to IDLE.
- A fetch always uses mem_we=0 and mem_data_type=FOUR_BYTE. For a D load, rdata is forwarded unmodified; extension is the memory controller's job.
- rdata registers hold their value until the next completion for the same port.
- If a requester drops req while in ISSUE, the transaction still completes and done still pulses. Requesters must not do this.
- An illegal state recovers to IDLE.

## Timing
- Reset (async, immediate): state IDLE; mem_req, mem_we, i_done, d_done = 0; grant=00; mem_addr, mem_wdata, i_rdata, d_rdata = 0; mem_data_type=0; last_grant=I.
- Grant latency: req seen high at edge N in IDLE gives mem_req=1 after edge N.
- mem_ready at edge M: done=1 and rdata valid in cycle M..M+1; mem_req=0 from M.
- Minimum turnaround is 3 cycles per transaction plus memory latency. Back-to-back grants to the same port are separated by the DONE cycle.
- Reset during ISSUE aborts the transaction and no done is produced. Memory must tolerate mem_req dropping.
- mem_ready while not in ISSUE is ignored.

## Structure
- ONE_BYTE/TWO_BYTE/FOUR_BYTE codes and the new ARB_IDLE/ARB_ISSUE/ARB_DONE state encodings go in the shared defines header, next to the existing D_CACHE_*/MEM_* codes.
- Grant encodings are exposed as ARB_GRANT_NONE/I/D constants in the same header.
- No sub-module; one always block for the FSM and a separate register block for the latched payload.

## Test plan
- Single D store: d_req=1, d_we=1, addr=0x100, wdata=0xDEADBEEF, FOUR_BYTE; memory replies 2 cycles later -> mem_* match, one d_done pulse, grant back to 00.
- Single fetch: i_req, addr=0x40, mem_rdata=0x00000013 -> i_rdata=0x13 with i_done; mem_we=0, type FOUR_BYTE.
- Simultaneous i_req and d_req after reset, both held -> D served first, then I, then D; no port is served twice in a row while the other waits.
- Requester changes d_addr to 0x200 after grant of 0x100 -> mem_addr stays 0x100 until mem_ready.
- Async rst asserted mid-ISSUE -> all outputs 0 immediately, no done pulse; the next request after reset is served normally.
- Spurious mem_ready in IDLE -> no done pulse, no state change.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared codes for the memory arbiter: access sizes, grant owners, FSM states.
// Also holds the round-robin pick shared by the arbiter.
package memory_arbiter_pkg;

   localparam logic [2:0] ONE_BYTE  = 3'd0;
   localparam logic [2:0] TWO_BYTE  = 3'd1;
   localparam logic [2:0] FOUR_BYTE = 3'd2;

   localparam logic [1:0] ARB_GRANT_NONE = 2'b00;
   localparam logic [1:0] ARB_GRANT_I    = 2'b01;
   localparam logic [1:0] ARB_GRANT_D    = 2'b10;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'b00,
      ARB_ISSUE = 2'b01,
      ARB_DONE  = 2'b10
   } arb_state_t;

   // On a tie the port that was not served last wins.
   function automatic logic [1:0] arb_pick(input logic       i_req,
                                           input logic       d_req,
                                           input logic [1:0] last_grant);
      if (d_req && (!i_req || last_grant == ARB_GRANT_I)) return ARB_GRANT_D;
      if (i_req) return ARB_GRANT_I;
      return ARB_GRANT_NONE;
   endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Requester, memory and grant signals of the arbiter.
// master = the arbiter itself, slave = the surrounding caches and memory.
interface memory_arbiter_if #(
   parameter int ADDR_WIDTH = 17,
   parameter int LEN        = 32
);
   logic                  i_req;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic [LEN-1:0]        i_rdata;
   logic                  i_done;

   logic                  d_req;
   logic                  d_we;
   logic [ADDR_WIDTH-1:0] d_addr;
   logic [LEN-1:0]        d_wdata;
   logic [2:0]            d_data_type;
   logic [LEN-1:0]        d_rdata;
   logic                  d_done;

   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [LEN-1:0]        mem_wdata;
   logic [2:0]            mem_data_type;
   logic [LEN-1:0]        mem_rdata;
   logic                  mem_ready;

   logic [1:0]            grant;

   modport master (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_data_type,
      input  mem_rdata, mem_ready,
      output i_rdata, i_done, d_rdata, d_done,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_data_type, grant
   );

   modport slave (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_data_type,
      output mem_rdata, mem_ready,
      input  i_rdata, i_done, d_rdata, d_done,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_data_type, grant
   );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one main-memory port between I-fetch and D-side.
// One transaction in flight; payload latched at grant; one DONE turnaround cycle.
module memory_arbiter
   import memory_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 17,
   parameter int LEN        = 32
) (
   input  logic             clk,
   input  logic             rst,
   memory_arbiter_if.master bus
);

   arb_state_t            state_q, state_d;
   logic [1:0]            grant_q, grant_d;
   logic [1:0]            last_grant_q, last_grant_d;
   logic [1:0]            pick;
   logic                  mem_req_q, mem_req_d;
   logic                  i_done_q, i_done_d;
   logic                  d_done_q, d_done_d;
   logic                  take_i, take_d, complete;

   logic                  mem_we_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [LEN-1:0]        mem_wdata_q;
   logic [2:0]            mem_type_q;
   logic [LEN-1:0]        i_rdata_q;
   logic [LEN-1:0]        d_rdata_q;

   assign pick = arb_pick(bus.i_req, bus.d_req, last_grant_q);

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      mem_req_d    = mem_req_q;
      i_done_d     = 1'b0;
      d_done_d     = 1'b0;
      take_i       = 1'b0;
      take_d       = 1'b0;
      complete     = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (pick != ARB_GRANT_NONE) begin
               grant_d   = pick;
               take_i    = (pick == ARB_GRANT_I);
               take_d    = (pick == ARB_GRANT_D);
               mem_req_d = 1'b1;
               state_d   = ARB_ISSUE;
            end
         end
         ARB_ISSUE: begin
            if (bus.mem_ready) begin
               complete  = 1'b1;
               mem_req_d = 1'b0;
               i_done_d  = (grant_q == ARB_GRANT_I);
               d_done_d  = (grant_q == ARB_GRANT_D);
               state_d   = ARB_DONE;
            end
         end
         // Requests are deliberately not sampled here so a requester
         // dropping req on done is never granted a second time.
         ARB_DONE: begin
            last_grant_d = grant_q;
            grant_d      = ARB_GRANT_NONE;
            state_d      = ARB_IDLE;
         end
         default: begin
            grant_d   = ARB_GRANT_NONE;
            mem_req_d = 1'b0;
            state_d   = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         grant_q      <= ARB_GRANT_NONE;
         last_grant_q <= ARB_GRANT_I;
         mem_req_q    <= 1'b0;
         i_done_q     <= 1'b0;
         d_done_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         mem_req_q    <= mem_req_d;
         i_done_q     <= i_done_d;
         d_done_q     <= d_done_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_type_q  <= 3'd0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else begin
         if (take_d) begin
            mem_we_q    <= bus.d_we;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
            mem_type_q  <= bus.d_data_type;
         end else if (take_i) begin
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.i_addr;
            mem_wdata_q <= '0;
            mem_type_q  <= FOUR_BYTE;
         end
         if (complete && grant_q == ARB_GRANT_I) i_rdata_q <= bus.mem_rdata;
         if (complete && grant_q == ARB_GRANT_D) d_rdata_q <= bus.mem_rdata;
      end
   end

   assign bus.mem_req       = mem_req_q;
   assign bus.mem_we        = mem_we_q;
   assign bus.mem_addr      = mem_addr_q;
   assign bus.mem_wdata     = mem_wdata_q;
   assign bus.mem_data_type = mem_type_q;
   assign bus.grant         = grant_q;
   assign bus.i_done        = i_done_q;
   assign bus.d_done        = d_done_q;
   assign bus.i_rdata       = i_rdata_q;
   assign bus.d_rdata       = d_rdata_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus randomized requesters and memory,
// all outputs compared each cycle against a transaction-level model.
module tb_memory_arbiter;
   import memory_arbiter_pkg::*;

   localparam int AW = 17;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   memory_arbiter_if #(.ADDR_WIDTH(AW), .LEN(DW)) bus();
   memory_arbiter #(.ADDR_WIDTH(AW), .LEN(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_chk  = 0;
   int n_fail = 0;

   logic        auto_mem = 1'b0;
   logic        man_rdy  = 1'b0;
   logic        auto_rdy = 1'b0;
   logic [31:0] man_dat  = 32'h0;
   logic [31:0] auto_dat = 32'h0;
   assign bus.mem_ready = auto_mem ? auto_rdy : man_rdy;
   assign bus.mem_rdata = auto_mem ? auto_dat : man_dat;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Transaction-level reference: owner 0 none / 1 I / 2 D.
   int          m_owner = 0;
   int          m_last  = 1;
   int          m_done_port = 0;
   bit          m_busy = 1'b0;
   bit          m_cool = 1'b0;
   logic        m_we    = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [31:0] m_wdata = 32'h0;
   logic [2:0]  m_type  = 3'd0;
   logic [31:0] m_rdata [1:2];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_owner = 0; m_last = 1; m_done_port = 0;
         m_busy = 1'b0; m_cool = 1'b0;
         m_we = 1'b0; m_addr = '0; m_wdata = 32'h0; m_type = 3'd0;
         m_rdata[1] = 32'h0; m_rdata[2] = 32'h0;
      end else begin
         m_done_port = 0;
         if (m_cool) begin
            m_last  = m_owner;
            m_owner = 0;
            m_cool  = 1'b0;
         end else if (m_busy) begin
            if (bus.mem_ready === 1'b1) begin
               m_rdata[m_owner] = bus.mem_rdata;
               m_busy      = 1'b0;
               m_cool      = 1'b1;
               m_done_port = m_owner;
            end
         end else if (bus.d_req && !(bus.i_req && m_last == 2)) begin
            m_owner = 2; m_busy = 1'b1;
            m_we = bus.d_we; m_addr = bus.d_addr; m_wdata = bus.d_wdata; m_type = bus.d_data_type;
         end else if (bus.i_req) begin
            m_owner = 1; m_busy = 1'b1;
            m_we = 1'b0; m_addr = bus.i_addr; m_type = FOUR_BYTE;
         end
      end
   end

   always @(negedge clk) begin
      chk("grant",     32'(bus.grant),         32'(m_owner));
      chk("mem_req",   32'(bus.mem_req),       32'(m_busy));
      chk("i_done",    32'(bus.i_done),        32'(m_done_port == 1));
      chk("d_done",    32'(bus.d_done),        32'(m_done_port == 2));
      chk("i_rdata",   bus.i_rdata,            m_rdata[1]);
      chk("d_rdata",   bus.d_rdata,            m_rdata[2]);
      chk("mem_addr",  32'(bus.mem_addr),      32'(m_addr));
      chk("mem_we",    32'(bus.mem_we),        32'(m_we));
      chk("mem_type",  32'(bus.mem_data_type), 32'(m_type));
      if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
   end

   // Random memory: variable latency, occasional spurious ready while idle.
   int lat = 0;
   always @(posedge clk) begin
      #1;
      if (!auto_mem) begin
         auto_rdy = 1'b0;
      end else if (auto_rdy) begin
         auto_rdy = 1'b0;
      end else if (bus.mem_req) begin
         if (lat == 0) begin
            auto_rdy = 1'b1;
            auto_dat = $urandom;
            lat      = $urandom_range(0, 3);
         end else begin
            lat--;
         end
      end else if ($urandom % 8 == 0) begin
         auto_rdy = 1'b1;
         auto_dat = $urandom;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   logic [1:0] order [$];
   int i_wait = 0;
   int d_wait = 0;
   int n_done = 0;

   initial begin
      bus.i_req = 1'b0; bus.i_addr = '0;
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = 32'h0; bus.d_data_type = 3'd0;
      #2 rst = 1'b1;
      #1;
      chk("rst_mem_req",   32'(bus.mem_req), 32'h0);
      chk("rst_grant",     32'(bus.grant), 32'h0);
      chk("rst_mem_addr",  32'(bus.mem_addr), 32'h0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
      chk("rst_mem_type",  32'(bus.mem_data_type), 32'h0);
      chk("rst_d_rdata",   bus.d_rdata, 32'h0);
      tick();
      rst = 1'b0;
      tick();

      // Single D store, memory answers two cycles after grant; bus changed after grant.
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 17'h100;
      bus.d_wdata = 32'hDEADBEEF; bus.d_data_type = FOUR_BYTE;
      tick();
      chk("st_grant",  32'(bus.grant), 32'h2);
      chk("st_model",  32'(m_owner), 32'h2);
      chk("st_req",    32'(bus.mem_req), 32'h1);
      chk("st_addr",   32'(bus.mem_addr), 32'h100);
      chk("st_wdata",  bus.mem_wdata, 32'hDEADBEEF);
      chk("st_we",     32'(bus.mem_we), 32'h1);
      chk("st_type",   32'(bus.mem_data_type), 32'(FOUR_BYTE));
      bus.d_addr = 17'h200; bus.d_wdata = 32'h0;
      tick();
      chk("st_hold_addr", 32'(bus.mem_addr), 32'h100);
      chk("st_no_done",   32'(bus.d_done), 32'h0);
      man_rdy = 1'b1; man_dat = 32'h0BADF00D;
      tick();
      man_rdy = 1'b0;
      chk("st_done",      32'(bus.d_done), 32'h1);
      chk("st_req_drop",  32'(bus.mem_req), 32'h0);
      chk("st_i_quiet",   32'(bus.i_done), 32'h0);
      bus.d_req = 1'b0;
      tick();
      chk("st_done_end",  32'(bus.d_done), 32'h0);
      chk("st_grant_end", 32'(bus.grant), 32'h0);

      // Single fetch.
      bus.i_req = 1'b1; bus.i_addr = 17'h40;
      tick();
      chk("if_grant", 32'(bus.grant), 32'h1);
      chk("if_we",    32'(bus.mem_we), 32'h0);
      chk("if_type",  32'(bus.mem_data_type), 32'(FOUR_BYTE));
      chk("if_addr",  32'(bus.mem_addr), 32'h40);
      man_rdy = 1'b1; man_dat = 32'h00000013;
      tick();
      man_rdy = 1'b0;
      chk("if_done",  32'(bus.i_done), 32'h1);
      chk("if_rdata", bus.i_rdata, 32'h13);
      chk("if_d_hold", bus.d_rdata, 32'h0BADF00D);
      bus.i_req = 1'b0;
      tick();
      chk("if_grant_end", 32'(bus.grant), 32'h0);

      // Spurious ready while idle.
      man_rdy = 1'b1; man_dat = 32'hFFFFFFFF;
      tick();
      chk("sp_i_done", 32'(bus.i_done), 32'h0);
      chk("sp_d_done", 32'(bus.d_done), 32'h0);
      chk("sp_req",    32'(bus.mem_req), 32'h0);
      chk("sp_rdata",  bus.i_rdata, 32'h13);
      man_rdy = 1'b0;
      tick();

      // Both held from reset: D, I, D.
      rst = 1'b1; #1 rst = 1'b0;
      bus.i_req = 1'b1; bus.i_addr = 17'h44;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 17'h120; bus.d_data_type = TWO_BYTE;
      man_rdy = 1'b1; man_dat = 32'h00001234;
      repeat (9) begin
         tick();
         if (bus.mem_req) order.push_back(bus.grant);
      end
      bus.i_req = 1'b0; bus.d_req = 1'b0; man_rdy = 1'b0;
      tick();
      chk("rr_count", 32'(order.size()), 32'h3);
      if (order.size() == 3) begin
         chk("rr_first",  32'(order[0]), 32'h2);
         chk("rr_second", 32'(order[1]), 32'h1);
         chk("rr_third",  32'(order[2]), 32'h2);
      end

      // Reset in the middle of a transaction.
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 17'h300;
      bus.d_wdata = 32'h55; bus.d_data_type = ONE_BYTE;
      tick();
      chk("ra_req", 32'(bus.mem_req), 32'h1);
      #1 rst = 1'b1;
      #1;
      chk("ra_req0",   32'(bus.mem_req), 32'h0);
      chk("ra_grant0", 32'(bus.grant), 32'h0);
      chk("ra_addr0",  32'(bus.mem_addr), 32'h0);
      chk("ra_we0",    32'(bus.mem_we), 32'h0);
      chk("ra_rdata0", bus.d_rdata, 32'h0);
      tick();
      chk("ra_no_done", 32'(bus.d_done), 32'h0);
      rst = 1'b0;
      tick();
      chk("ra_regrant", 32'(bus.grant), 32'h2);
      chk("ra_addr",    32'(bus.mem_addr), 32'h300);
      man_rdy = 1'b1; man_dat = 32'h77;
      tick();
      man_rdy = 1'b0;
      chk("ra_done",  32'(bus.d_done), 32'h1);
      chk("ra_rdata", bus.d_rdata, 32'h77);
      bus.d_req = 1'b0;
      tick();
      tick();

      // Randomized traffic.
      auto_mem = 1'b1;
      repeat (4000) begin
         tick();
         if (bus.i_done) begin
            n_done++; i_wait = 0;
            bus.i_req = ($urandom % 4 == 0);
            bus.i_addr = 17'($urandom);
         end else if (!bus.i_req) begin
            if ($urandom % 3 == 0) begin
               bus.i_req = 1'b1; bus.i_addr = 17'($urandom); i_wait = 0;
            end
         end else begin
            i_wait++;
            if ($urandom % 4 == 0) bus.i_addr = 17'($urandom);
         end
         if (bus.d_done) begin
            n_done++; d_wait = 0;
            bus.d_req = ($urandom % 4 == 0);
            bus.d_we = 1'($urandom); bus.d_addr = 17'($urandom);
            bus.d_wdata = $urandom; bus.d_data_type = 3'($urandom_range(0, 2));
         end else if (!bus.d_req) begin
            if ($urandom % 3 == 0) begin
               bus.d_req = 1'b1; d_wait = 0;
               bus.d_we = 1'($urandom); bus.d_addr = 17'($urandom);
               bus.d_wdata = $urandom; bus.d_data_type = 3'($urandom_range(0, 2));
            end
         end else begin
            d_wait++;
            if ($urandom % 4 == 0) begin
               bus.d_addr = 17'($urandom); bus.d_wdata = $urandom; bus.d_we = 1'($urandom);
            end
         end
         if (i_wait > 40) begin chk("i_starved", 32'(i_wait), 32'd40); i_wait = 0; end
         if (d_wait > 40) begin chk("d_starved", 32'(d_wait), 32'd40); d_wait = 0; end
      end

      // Let outstanding requests finish, raising no new ones.
      repeat (60) begin
         tick();
         if (bus.i_done) bus.i_req = 1'b0;
         if (bus.d_done) bus.d_req = 1'b0;
      end
      chk("drained",   32'({bus.i_req, bus.d_req}), 32'h0);
      chk("txn_count", 32'(n_done > 300), 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
